profile_snapshot_ci: RTL

- Custom-instruction block sitting directly downstream of the profiling counter CI.
- Consumes the four 32-bit profiling counter values and captures them atomically into snapshot registers.
- Returns per-counter deltas since the last snapshot, raw snapshots, or a status word.
- Lets software measure code regions with one snapshot CI and one delta CI per counter, with no read-modify arithmetic on the CPU.

---
 rtl/profile_snapshot_ci.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/profile_snapshot_ci.sv
// profile_snapshot_ci: custom-instruction block sitting behind the profiling
// counter CI. It captures the four counter values coherently on accept, and
// returns per-counter deltas since the last snapshot, raw snapshot values, or
// a status word. Each instruction takes IDLE -> EXEC -> DONE, and done/result
// are presented for the single DONE cycle.
module profile_snapshot_ci #(
  parameter logic [7:0] customId = 8'h18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [31:0] counter0,
  input  logic [31:0] counter1,
  input  logic [31:0] counter2,
  input  logic [31:0] counter3,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_SNAP     = 2'd0;
  localparam logic [1:0] OP_DELTA    = 2'd1;
  localparam logic [1:0] OP_READSNAP = 2'd2;
  localparam logic [1:0] OP_STATUS   = 2'd3;

  // Saturating increment for the snapshot counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Modular difference; wrap is reported separately by the caller.
  function automatic logic [31:0] mod_delta(input logic [31:0] now_v,
                                            input logic [31:0] base_v);
    return now_v - base_v;
  endfunction

  // Status word layout: {count[15:0], 7'b0, valid, 4'b0, wrap[3:0]}.
  function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                              input logic        valid,
                                              input logic [3:0]  wrap);
    return {cnt, 7'b0, valid, 4'b0, wrap};
  endfunction

  // Control state
  logic [1:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  op_q, op_d;

  // Coherent counter samples taken at the accept edge
  logic [31:0] cnt_q [4];
  logic [31:0] cnt_d [4];

  // Snapshot bookkeeping
  logic [31:0] snap_q [4];
  logic [31:0] snap_d [4];
  logic        snap_valid_q, snap_valid_d;
  logic [3:0]  wrap_q, wrap_d;
  logic [15:0] snap_count_q, snap_count_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic        in_exec;
  logic [31:0] cnt_sel;
  logic [31:0] snap_sel;

  // Operand bits that are reserved and deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{valueB, valueA[31:4]};

  assign accept   = start && (ciN == customId) && (state_q == ST_IDLE);
  assign in_exec  = (state_q == ST_EXEC);
  assign cnt_sel  = cnt_q[sel_q];
  assign snap_sel = snap_q[sel_q];

  // FSM sequencing: a start outside IDLE is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand and counter capture; all four counters latch on the same edge.
  always_comb begin
    sel_d = sel_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (accept) begin
      sel_d    = valueA[1:0];
      op_d     = valueA[3:2];
      cnt_d[0] = counter0;
      cnt_d[1] = counter1;
      cnt_d[2] = counter2;
      cnt_d[3] = counter3;
    end
  end

  // Operation execution in EXEC, working only from the captured samples.
  always_comb begin
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    wrap_d       = wrap_q;
    snap_count_d = snap_count_q;
    result_d     = result_q;
    if (in_exec) begin
      case (op_q)
        OP_SNAP: begin
          snap_d       = cnt_q;
          snap_valid_d = 1'b1;
          wrap_d       = 4'b0;
          snap_count_d = sat_inc16(snap_count_q);
          result_d     = {16'h0, snap_count_q};
        end
        OP_DELTA: begin
          if (snap_valid_q) begin
            result_d = mod_delta(cnt_sel, snap_sel);
            // Sticky until the next SNAP; the modular result is still returned.
            if (cnt_sel < snap_sel) wrap_d[sel_q] = 1'b1;
          end else begin
            result_d = cnt_sel;
          end
        end
        OP_READSNAP: result_d = snap_sel;
        OP_STATUS:   result_d = pack_status(snap_count_q, snap_valid_q, wrap_q);
      endcase
    end
  end

  // State registers; reset abandons any in-flight instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'b0;
      op_q         <= 2'b0;
      snap_valid_q <= 1'b0;
      wrap_q       <= 4'b0;
      snap_count_q <= 16'h0;
      result_q     <= 32'h0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= 32'h0;
        snap_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      wrap_q       <= wrap_d;
      snap_count_q <= snap_count_d;
      result_q     <= result_d;
    end
  end

  // The result bus is forced to zero outside the DONE cycle.
  assign done   = (state_q == ST_DONE);
  assign result = done ? result_q : 32'h0;

endmodule
